// File: rtl/img_loader.sv
// Image loader: writes a valid/ready pixel stream row-major into BRAM port A, swapping {b,g,r} to {r,g,b}.
// Optional IMG_LOADER_CHECKSUM_EN adds a 16-bit running sum of accepted pixels on port checksum.
module img_loader #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 380,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [11:0]       in_pixel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_din,
    output logic              busy,
`ifdef IMG_LOADER_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic              done
);

    // state | meaning
    // IDLE  | waiting for start
    // WRITE | accepting pixels, one write per handshake
    // FLUSH | final pixel write on the bus, done follows
    typedef enum logic [1:0] {IDLE, WRITE, FLUSH} state_t;

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    state_t            state, next_state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] wr_ptr;
    logic              hs, accept, last_px, enter_write;

    assign hs          = in_valid && in_ready;
    assign accept      = hs && !abort;
    assign last_px     = (row == ROW_W'(HEIGHT - 1)) && (col == COL_W'(WIDTH - 1));
    assign enter_write = (state == IDLE) && (next_state == WRITE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && !abort) next_state = WRITE;
            WRITE:   begin
                if (abort)                 next_state = IDLE;
                else if (hs && last_px)    next_state = FLUSH;
            end
            FLUSH:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            col      <= '0;
            row      <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state == WRITE);
            busy     <= (next_state != IDLE);
            done     <= (state == FLUSH) && !abort;
            mem_we   <= accept;
            if (enter_write) begin
                col    <= '0;
                row    <= '0;
                wr_ptr <= '0;
            end else if (accept) begin
                mem_addr <= wr_ptr;
                mem_din  <= {in_pixel[3:0], in_pixel[7:4], in_pixel[11:8]};
                wr_ptr   <= wr_ptr + 1'b1;
                // pointer tracks row*WIDTH+col without a multiplier
                if (col == COL_W'(WIDTH - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

`ifdef IMG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)              checksum <= '0;
        else if (enter_write) checksum <= '0;
        else if (accept)      checksum <= checksum + {4'b0000, in_pixel};
    end
`endif

endmodule

// File: tb/tb_img_loader.sv
// Randomised bench for img_loader: a small 4x3 instance and a default 160x380 instance,
// both checked every cycle against a frame-level behavioural model.
module tb_img_loader;
    localparam int AW = 19;
    localparam int W0 = 4, H0 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [1:0]  start = '0, abort = '0, in_valid = '0;
    logic [1:0]  in_ready, mem_we, busy, done;
    logic [11:0] in_pixel [2];
    logic [11:0] mem_din [2];
    logic [AW-1:0] mem_addr [2];
`ifdef IMG_LOADER_CHECKSUM_EN
    logic [15:0] checksum [2];
`endif

    int n_chk = 0, n_fail = 0;
    int tot [2];
    bit m_act [2], m_fl [2], m_we [2], m_busy [2], m_done [2], m_ready [2];
    int m_n [2];
    logic [AW-1:0] m_addr [2];
    logic [11:0]   m_din [2];
    logic [15:0]   m_ck [2];
    int n_we [2], n_done [2];

    img_loader #(.WIDTH(W0), .HEIGHT(H0), .ADDR_W(AW)) u_small (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_pixel(in_pixel[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]),
        .busy(busy[0]),
`ifdef IMG_LOADER_CHECKSUM_EN
        .checksum(checksum[0]),
`endif
        .done(done[0])
    );

    img_loader u_big (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_pixel(in_pixel[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]),
        .busy(busy[1]),
`ifdef IMG_LOADER_CHECKSUM_EN
        .checksum(checksum[1]),
`endif
        .done(done[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] swp(input logic [11:0] p);
        return {p[3:0], p[7:4], p[11:8]};
    endfunction

    // Frame-level reference: pixel count n is the write address; outputs are those after the edge.
    task automatic model(input int k, input bit st, input bit ab, input bit v,
                         input logic [11:0] px, input bit rs);
        bit hs;
        hs = v && m_ready[k];
        m_we[k]   = 1'b0;
        m_done[k] = 1'b0;
        if (rs) begin
            m_act[k] = 0; m_fl[k] = 0; m_n[k] = 0; m_ready[k] = 0; m_busy[k] = 0;
            m_addr[k] = '0; m_din[k] = '0; m_ck[k] = '0;
        end else if (ab) begin
            m_act[k] = 0; m_fl[k] = 0; m_ready[k] = 0; m_busy[k] = 0;
        end else if (m_fl[k]) begin
            m_fl[k] = 0; m_done[k] = 1; m_busy[k] = 0;
        end else if (m_act[k]) begin
            if (hs) begin
                m_we[k]   = 1'b1;
                m_addr[k] = AW'(m_n[k]);
                m_din[k]  = swp(px);
                m_ck[k]   = m_ck[k] + {4'b0000, px};
                m_n[k]++;
                if (m_n[k] == tot[k]) begin
                    m_act[k] = 0; m_fl[k] = 1; m_ready[k] = 0;
                end
            end
        end else if (st) begin
            m_act[k] = 1; m_n[k] = 0; m_ready[k] = 1; m_busy[k] = 1; m_ck[k] = '0;
        end
    endtask

    task automatic check_outputs(input int k);
        chk($sformatf("in_ready%0d", k), 32'(in_ready[k]), 32'(m_ready[k]));
        chk($sformatf("mem_we%0d", k),   32'(mem_we[k]),   32'(m_we[k]));
        chk($sformatf("mem_addr%0d", k), 32'(mem_addr[k]), 32'(m_addr[k]));
        chk($sformatf("mem_din%0d", k),  32'(mem_din[k]),  32'(m_din[k]));
        chk($sformatf("busy%0d", k),     32'(busy[k]),     32'(m_busy[k]));
        chk($sformatf("done%0d", k),     32'(done[k]),     32'(m_done[k]));
`ifdef IMG_LOADER_CHECKSUM_EN
        chk($sformatf("checksum%0d", k), 32'(checksum[k]), 32'(m_ck[k]));
`endif
        if (mem_we[k] === 1'b1) n_we[k]++;
        if (done[k] === 1'b1)   n_done[k]++;
    endtask

    // One clock: drive DUT d (the other idles), advance the model, check both on the falling edge.
    task automatic step(input int d, input bit st, input bit ab, input bit v,
                        input logic [11:0] px, input bit rs);
        for (int k = 0; k < 2; k++) begin
            start[k]    = (k == d) && st;
            abort[k]    = (k == d) && ab;
            in_valid[k] = (k == d) && v;
            in_pixel[k] = (k == d) ? px : 12'h000;
            model(k, start[k], abort[k], in_valid[k], in_pixel[k], rs);
        end
        rst = rs;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_outputs(k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 12'h000, 0);
    endtask

    task automatic clr_counts();
        for (int k = 0; k < 2; k++) begin n_we[k] = 0; n_done[k] = 0; end
    endtask

    initial begin
        int cyc;
        tot[0] = W0 * H0;
        tot[1] = 160 * 380;
        in_pixel[0] = '0;
        in_pixel[1] = '0;
        @(negedge clk);
        step(0, 0, 0, 0, 12'h000, 1);
        step(0, 1, 0, 1, 12'h123, 1);
        idle(2);

        // full small frame, back-to-back 0x001..0x00C
        clr_counts();
        step(0, 1, 0, 0, 12'h000, 0);
        for (int i = 1; i <= 12; i++) step(0, 0, 0, 1, 12'(i), 0);
        idle(3);
        chk("full_writes", 32'(n_we[0]), 32'd12);
        chk("full_done", 32'(n_done[0]), 32'd1);

        // gaps: valid 1,0,0,1 then abort
        clr_counts();
        step(0, 1, 0, 0, 12'h000, 0);
        step(0, 0, 0, 1, 12'($urandom), 0);
        step(0, 0, 0, 0, 12'($urandom), 0);
        step(0, 0, 0, 0, 12'($urandom), 0);
        step(0, 0, 0, 1, 12'($urandom), 0);
        step(0, 0, 1, 0, 12'h000, 0);
        idle(2);
        chk("gap_writes", 32'(n_we[0]), 32'd2);

        // abort concurrent with handshake of pixel 5
        clr_counts();
        step(0, 1, 0, 0, 12'h000, 0);
        for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 12'($urandom), 0);
        step(0, 0, 1, 1, 12'h555, 0);
        idle(3);
        chk("abort_writes", 32'(n_we[0]), 32'd4);
        chk("abort_done", 32'(n_done[0]), 32'd0);

        // start/abort collision in idle must stay idle
        step(0, 1, 1, 1, 12'h0AA, 0);
        idle(1);

        // rst on the cycle of pixel 7
        clr_counts();
        step(0, 1, 0, 0, 12'h000, 0);
        for (int i = 1; i <= 6; i++) step(0, 0, 0, 1, 12'($urandom), 0);
        step(0, 0, 0, 1, 12'h777, 1);
        chk("rst_addr", 32'(mem_addr[0]), 32'd0);
        idle(2);
        chk("rst_writes", 32'(n_we[0]), 32'd6);

`ifdef IMG_LOADER_CHECKSUM_EN
        step(0, 1, 0, 0, 12'h000, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 12'hFFF, 0);
        step(0, 0, 0, 0, 12'h000, 0);
        chk("checksum_fff", 32'(checksum[0]), 32'h0000BFF4);
        idle(2);
`endif

        // random frames: gaps, stray starts while busy, occasional abort
        for (int f = 0; f < 25; f++) begin
            step(0, 1, 0, 0, 12'h000, 0);
            cyc = 0;
            while ((m_act[0] || m_fl[0]) && cyc < 200) begin
                step(0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0),
                     ($urandom_range(0, 3) != 0), 12'($urandom), 0);
                cyc++;
            end
            idle($urandom_range(1, 3));
        end

        // full default-size frame: row wrap at 160, last address 60799
        clr_counts();
        step(1, 1, 0, 0, 12'h000, 0);
        cyc = 0;
        while ((m_act[1] || m_fl[1]) && cyc < 70000) begin
            step(1, ($urandom_range(0, 999) == 0), 0, ($urandom_range(0, 31) != 0),
                 12'($urandom), 0);
            cyc++;
        end
        idle(2);
        chk("big_writes", 32'(n_we[1]), 32'd60800);
        chk("big_done", 32'(n_done[1]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
